// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg: shared constants, job descriptor and FSM types for the matmul sequencer
package matrix_mult_pkg;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int PSUM_LEAD = 1;
  localparam int TIMEOUT = 1023;
  localparam int W_SIZE = 64;
  localparam int I_SIZE = 256;
  localparam int O_SIZE = 256;
  localparam int WAW = $clog2(W_SIZE);
  localparam int IAW = $clog2(I_SIZE);
  localparam int OAW = $clog2(O_SIZE);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int CTRL_PIPE_LAT = ROW + COL - 1;
  localparam int PSUM_DLY = CTRL_PIPE_LAT - PSUM_LEAD;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} ctrl_state_e;
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
  } ctrl_status_struct;
  typedef struct packed {
    logic           accum_en;
    logic [OAW-1:0] o_offset_w;
    logic [OAW-1:0] psum_offset;
    logic [IAW-1:0] i_offset;
    logic [WAW-1:0] w_offset;
    logic [7:0]     i_rows;
    logic [1:0]     w_cols;
    logic [1:0]     w_rows;
  } data_config_struct;
endpackage

// File: rtl/matrix_mult_addr_gen.sv
// matrix_mult_addr_gen: captured offset plus running count, wrapped to AW bits, with last/full flags
module matrix_mult_addr_gen #(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [AW-1:0] offset_i,
  input  logic [LW-1:0] limit_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o,
  output logic          full_o
);
  logic [AW-1:0] offset;
  logic [LW-1:0] limit;
  logic [LW:0]   cnt;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      offset <= '0;
      limit  <= '0;
      cnt    <= '0;
    end else if (clr_i) begin
      offset <= offset_i;
      limit  <= limit_i;
      cnt    <= '0;
    end else if (inc_i)
      cnt <= cnt + (LW+1)'(1);
  assign addr_o = offset + AW'(cnt);
  assign last_o = cnt == {1'b0, limit};
  assign full_o = cnt > {1'b0, limit};
endmodule

// File: rtl/matrix_mult_ctrl.sv
// matrix_mult_ctrl: weight-preload/stream/drain sequencer for the 4x4 systolic array; MATRIX_MULT_CTRL_PERF_EN adds cycle counters
module matrix_mult_ctrl
  import matrix_mult_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  data_config_struct cfg_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              w_rd_en_o,
  output logic [WAW-1:0]    w_addr_o,
  output logic              w_load_o,
  output logic              i_rd_en_o,
  output logic [IAW-1:0]    i_addr_o,
  input  logic              stall_i,
  output logic              psum_rd_en_o,
  output logic [OAW-1:0]    psum_addr_o,
  input  logic              out_valid_i,
  output logic              o_wr_en_o,
  output logic [OAW-1:0]    o_addr_o,
  output logic              accum_o
`ifdef MATRIX_MULT_CTRL_PERF_EN
  ,
  output logic [31:0]       cycles_o,
  output logic [31:0]       stall_cycles_o
`endif
);
  ctrl_state_e       state, state_n;
  ctrl_status_struct st;
  logic              start, err, timeout;
  logic              w_last, i_last, o_full;
  logic              w_full, i_full, p_last, p_full, o_last, unused_ok;
  logic [PSUM_DLY-1:0] psum_sr;
  logic [WDW-1:0]    wd;
  assign start = state == IDLE && start_i;
  assign timeout = wd == WDW'(TIMEOUT - 1);
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? LOAD_W : IDLE;
      LOAD_W:  state_n = w_last ? STREAM : LOAD_W;
      STREAM:  state_n = (i_rd_en_o && i_last) ? DRAIN : STREAM;
      DRAIN:   state_n = (o_full || timeout) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    w_rd_en_o = state == LOAD_W;
    i_rd_en_o = state == STREAM && !stall_i;
    o_wr_en_o = out_valid_i && (state == STREAM || state == DRAIN);
    st.busy   = state inside {LOAD_W, STREAM, DRAIN};
    st.done   = state == DONE;
    st.err    = err;
  end
  assign {busy_o, done_o, err_o} = st;
  assign psum_rd_en_o = accum_o && psum_sr[PSUM_DLY-1];
  always_ff @(posedge clk_i)
    if (rst_i) begin
      err      <= 1'b0;
      accum_o  <= 1'b0;
      w_load_o <= 1'b0;
      psum_sr  <= '0;
      wd       <= '0;
    end else begin
      w_load_o <= w_rd_en_o;
      psum_sr  <= {psum_sr[PSUM_DLY-2:0], i_rd_en_o};
      wd       <= (state == DRAIN) ? wd + WDW'(1) : '0;
      if (start) begin
        err     <= 1'b0;
        accum_o <= cfg_i.accum_en;
      end else if (state == DRAIN && !o_full && timeout)
        err <= 1'b1;
    end
  matrix_mult_addr_gen #(.AW(WAW), .LW(2)) u_w (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start), .inc_i(w_rd_en_o),
    .offset_i(cfg_i.w_offset), .limit_i(cfg_i.w_rows),
    .addr_o(w_addr_o), .last_o(w_last), .full_o(w_full)
  );
  matrix_mult_addr_gen #(.AW(IAW), .LW(8)) u_i (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start), .inc_i(i_rd_en_o),
    .offset_i(cfg_i.i_offset), .limit_i(cfg_i.i_rows),
    .addr_o(i_addr_o), .last_o(i_last), .full_o(i_full)
  );
  matrix_mult_addr_gen #(.AW(OAW), .LW(8)) u_p (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start), .inc_i(psum_rd_en_o),
    .offset_i(cfg_i.psum_offset), .limit_i(cfg_i.i_rows),
    .addr_o(psum_addr_o), .last_o(p_last), .full_o(p_full)
  );
  matrix_mult_addr_gen #(.AW(OAW), .LW(8)) u_o (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(start), .inc_i(o_wr_en_o),
    .offset_i(cfg_i.o_offset_w), .limit_i(cfg_i.i_rows),
    .addr_o(o_addr_o), .last_o(o_last), .full_o(o_full)
  );
  assign unused_ok = &{1'b0, cfg_i.w_cols, w_full, i_full, p_last, p_full, o_last};
`ifdef MATRIX_MULT_CTRL_PERF_EN
  always_ff @(posedge clk_i)
    if (rst_i || start) begin
      cycles_o       <= '0;
      stall_cycles_o <= '0;
    end else begin
      cycles_o       <= cycles_o + 32'(st.busy);
      stall_cycles_o <= stall_cycles_o + 32'(state == STREAM && stall_i);
    end
`endif
endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb_matrix_mult_ctrl: random and directed jobs checked every cycle against a job-level reference model
module tb_matrix_mult_ctrl;
  import matrix_mult_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i, start_i, stall_i, out_valid_i;
  data_config_struct cfg_i;
  logic busy_o, done_o, err_o, w_rd_en_o, w_load_o, i_rd_en_o, psum_rd_en_o, o_wr_en_o, accum_o;
  logic [WAW-1:0] w_addr_o;
  logic [IAW-1:0] i_addr_o;
  logic [OAW-1:0] psum_addr_o, o_addr_o;
`ifdef MATRIX_MULT_CTRL_PERF_EN
  logic [31:0] cycles_o, stall_cycles_o;
`endif
  always #5 clk_i = ~clk_i;
  matrix_mult_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cfg_i(cfg_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .w_rd_en_o(w_rd_en_o), .w_addr_o(w_addr_o), .w_load_o(w_load_o),
    .i_rd_en_o(i_rd_en_o), .i_addr_o(i_addr_o), .stall_i(stall_i),
    .psum_rd_en_o(psum_rd_en_o), .psum_addr_o(psum_addr_o),
    .out_valid_i(out_valid_i), .o_wr_en_o(o_wr_en_o), .o_addr_o(o_addr_o),
    .accum_o(accum_o)
`ifdef MATRIX_MULT_CTRL_PERF_EN
    , .cycles_o(cycles_o), .stall_cycles_o(stall_cycles_o)
`endif
  );
  int checks = 0, errors = 0, cyc = 0;
  bit ov_at[int], ps_at[int];
  bit active = 0, acc_cap = 0, err_exp = 0, withhold = 0, rst_prev = 0, wexp_prev = 0;
  int s_cyc = 0, n_w = 0, n_in = 0, issued = 0, writes = 0, t_last = 0, u_last = 0, stalls = 0;
  int done_cnt = 0, done_at = 0, stall_mode = 0;
  data_config_struct jc;
  int w_log[$], i_log[$], p_log[$], o_log[$];
  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk_seq(string name, int q[$], int first, int n, int m);
    chk({name, "_count"}, q.size(), n);
    foreach (q[k]) chk(name, q[k], (first + k) % m);
  endtask
  always @(negedge clk_i) begin
    bit we, ie, pe, oe, de, full_ok, idle;
    int ss;
    if (rst_i) begin
      active = 0;
      acc_cap = 0;
      err_exp = 0;
      wexp_prev = 0;
      rst_prev = 1;
      ov_at.delete();
      ps_at.delete();
    end else begin
      if (rst_prev)
        chk("reset_all_zero", {busy_o, done_o, err_o, w_rd_en_o, w_addr_o, w_load_o, i_rd_en_o, i_addr_o,
                               psum_rd_en_o, psum_addr_o, o_wr_en_o, o_addr_o, accum_o}, 0);
      rst_prev = 0;
      idle = !active;
      ss = s_cyc + n_w + 1;
      full_ok = writes == n_in && u_last < cyc - 1;
      we = active && cyc <= s_cyc + n_w;
      de = active && issued == n_in && cyc >= t_last + 2 && (full_ok || cyc == t_last + 1024);
      ie = active && cyc >= ss && issued < n_in && !stall_i;
      pe = acc_cap && ps_at.exists(cyc);
      oe = out_valid_i && active && cyc >= ss && !de;
      if (de && !full_ok) err_exp = 1;
      chk("busy", busy_o, active && !de);
      chk("done", done_o, de);
      chk("err", err_o, err_exp);
      chk("w_rd_en", w_rd_en_o, we);
      chk("w_load", w_load_o, wexp_prev);
      chk("i_rd_en", i_rd_en_o, ie);
      chk("psum_rd_en", psum_rd_en_o, pe);
      chk("o_wr_en", o_wr_en_o, oe);
      chk("accum", accum_o, acc_cap);
      if (w_rd_en_o) w_log.push_back(int'(w_addr_o));
      if (i_rd_en_o) i_log.push_back(int'(i_addr_o));
      if (psum_rd_en_o) p_log.push_back(int'(psum_addr_o));
      if (o_wr_en_o) o_log.push_back(int'(o_addr_o));
      if (we) chk("w_addr", w_addr_o, (jc.w_offset + cyc - s_cyc - 1) % W_SIZE);
      if (active && cyc >= ss && issued < n_in && stall_i) stalls++;
      if (ie) begin
        chk("i_addr", i_addr_o, (jc.i_offset + issued) % I_SIZE);
        if (!(withhold && issued == n_in - 1)) ov_at[cyc + CTRL_PIPE_LAT] = 1;
        ps_at[cyc + CTRL_PIPE_LAT - PSUM_LEAD] = 1;
        issued++;
        t_last = cyc;
      end
      if (pe) begin
        chk("psum_addr", psum_addr_o, (jc.psum_offset + p_log.size() - 1) % O_SIZE);
        if (!withhold) chk("psum_lead", ov_at.exists(cyc + PSUM_LEAD), 1);
      end
      if (oe) begin
        chk("o_addr", o_addr_o, (jc.o_offset_w + writes) % O_SIZE);
        writes++;
        u_last = cyc;
      end
      wexp_prev = we;
      if (de) begin
        active = 0;
        done_cnt++;
        done_at = cyc;
`ifdef MATRIX_MULT_CTRL_PERF_EN
        chk("perf_cycles", cycles_o, cyc - s_cyc - 1);
        chk("perf_stalls", stall_cycles_o, stalls);
`endif
      end
      if (start_i && idle) begin
        jc = cfg_i;
        s_cyc = cyc;
        n_w = int'(cfg_i.w_rows) + 1;
        n_in = int'(cfg_i.i_rows) + 1;
        issued = 0;
        writes = 0;
        stalls = 0;
        u_last = 0;
        acc_cap = cfg_i.accum_en;
        err_exp = 0;
        active = 1;
        w_log.delete();
        i_log.delete();
        p_log.delete();
        o_log.delete();
      end
    end
    cyc++;
  end
  always @(posedge clk_i) begin
    #1;
    out_valid_i = ov_at.exists(cyc);
    stall_i = stall_mode == 1 ? ($urandom_range(0, 3) == 0) :
              stall_mode == 2 ? (active && cyc >= s_cyc + n_w + 2 && cyc <= s_cyc + n_w + 4) : 1'b0;
  end
  task automatic start_job(data_config_struct c);
    @(posedge clk_i);
    #1;
    start_i = 1;
    cfg_i = c;
    @(posedge clk_i);
    #1;
    start_i = 0;
  endtask
  task automatic wait_done(int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    chk("done_within_budget", done_cnt - d0, 1);
    @(posedge clk_i);
    #1;
  endtask
  function automatic data_config_struct basic(logic acc);
    data_config_struct c;
    c = '0;
    c.w_rows = 3;
    c.i_rows = 7;
    c.i_offset = 16;
    c.o_offset_w = 32;
    c.accum_en = acc;
    return c;
  endfunction
  initial begin
    data_config_struct c;
    int d0;
    rst_i = 1;
    start_i = 0;
    cfg_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 0;
    start_job(basic(0));
    wait_done(500);
    chk_seq("basic_w", w_log, 0, 4, W_SIZE);
    chk_seq("basic_i", i_log, 16, 8, I_SIZE);
    chk_seq("basic_o", o_log, 32, 8, O_SIZE);
    chk("basic_psum_reads", p_log.size(), 0);
    chk("basic_done_count", done_cnt, 1);
    c = basic(1);
    c.psum_offset = 64;
    start_job(c);
    wait_done(500);
    chk_seq("accum_p", p_log, 64, 8, O_SIZE);
    chk("accum_hold", accum_o, 1);
    stall_mode = 2;
    start_job(basic(0));
    wait_done(500);
    stall_mode = 0;
    chk_seq("stall_i", i_log, 16, 8, I_SIZE);
    chk_seq("stall_o", o_log, 32, 8, O_SIZE);
    chk("stall_count", stalls, 3);
    c = basic(0);
    c.i_offset = 252;
    c.o_offset_w = 254;
    start_job(c);
    wait_done(500);
    chk_seq("wrap_i", i_log, 252, 8, I_SIZE);
    chk_seq("wrap_o", o_log, 254, 8, O_SIZE);
    c = basic(0);
    c.i_rows = 3;
    withhold = 1;
    start_job(c);
    wait_done(1500);
    withhold = 0;
    chk("timeout_err", err_o, 1);
    chk("timeout_span", done_at - t_last, 1024);
    chk("timeout_writes", o_log.size(), 3);
    c = basic(0);
    c.i_rows = 30;
    d0 = done_cnt;
    start_job(c);
    for (int k = 0; k < 200 && i_log.size() < 5; k++) @(posedge clk_i);
    #1;
    rst_i = 1;
    @(posedge clk_i);
    #1;
    rst_i = 0;
    repeat (3) @(posedge clk_i);
    chk("reset_no_done", done_cnt - d0, 0);
    start_job(basic(0));
    wait_done(500);
    chk("post_reset_err", err_o, 0);
    chk_seq("post_reset_o", o_log, 32, 8, O_SIZE);
    start_job(basic(0));
    for (int k = 0; k < 200 && i_log.size() < 3; k++) @(posedge clk_i);
    #1;
    start_i = 1;
    cfg_i.i_offset = 99;
    cfg_i.o_offset_w = 77;
    cfg_i.w_rows = 0;
    @(posedge clk_i);
    #1;
    start_i = 0;
    wait_done(500);
    chk_seq("busy_start_i", i_log, 16, 8, I_SIZE);
    chk_seq("busy_start_o", o_log, 32, 8, O_SIZE);
    for (int j = 0; j < 12; j++) begin
      c.w_rows = 2'($urandom);
      c.w_cols = 2'($urandom);
      c.i_rows = 8'($urandom_range(0, 40));
      c.w_offset = WAW'($urandom);
      c.i_offset = IAW'($urandom);
      c.psum_offset = OAW'($urandom);
      c.o_offset_w = OAW'($urandom);
      c.accum_en = 1'($urandom);
      stall_mode = $urandom_range(0, 1);
      start_job(c);
      wait_done(1000);
      chk("rand_writes", o_log.size(), int'(c.i_rows) + 1);
    end
    stall_mode = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_mult_ctrl.md
Name: matrix_mult_ctrl

Overview:
- Sequencer for the 4x4 weight-stationary systolic matrix-multiply datapath.
- Accepts one job descriptor (data_config_struct) per start pulse.
- Phase 1: preloads weights from weight SRAM into the array.
- Phase 2: streams input rows from input SRAM, optionally reads partial sums for accumulation, and writes array results to output SRAM.
- Sits between the host/config register file and the array plus its three SRAMs.

Parameters:
- ROW, 4, array rows (from matrix_mult_pkg)
- COL, 4, array columns (from matrix_mult_pkg)
- PSUM_LEAD, 1, cycles psum_rd_en precedes the matching out_valid_i (SRAM read latency)
- TIMEOUT, 1023, max cycles in DRAIN waiting for outputs before error

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  job start pulse; sampled only in IDLE
- cfg_i  in  $bits(data_config_struct)  job descriptor; captured on accepted start
- busy_o  out  1  high from accepted start until the cycle done_o is asserted
- done_o  out  1  one-cycle pulse at job completion
- err_o  out  1  sticky drain timeout; cleared by next accepted start
- w_rd_en_o  out  1  weight SRAM read enable
- w_addr_o  out  $clog2(W_SIZE)  weight SRAM address
- w_load_o  out  1  array weight-shift enable; w_rd_en_o delayed by 1
- i_rd_en_o  out  1  input SRAM read enable
- i_addr_o  out  $clog2(I_SIZE)  input SRAM address
- stall_i  in  1  freezes input issue while high
- psum_rd_en_o  out  1  psum SRAM read enable; only when accum_en
- psum_addr_o  out  $clog2(O_SIZE)  psum SRAM address
- out_valid_i  in  1  array result row valid
- o_wr_en_o  out  1  output SRAM write enable, equal to out_valid_i while in STREAM/DRAIN
- o_addr_o  out  $clog2(O_SIZE)  output SRAM address
- accum_o  out  1  selects psum adder in the output path; captured accum_en

Behaviour:
- Reset: every output is 0. State is IDLE. All counters are 0.
- Register fields encode counts minus one:
  - weight rows = w_rows+1 (1..4)
  - input rows = i_rows+1 (1..256)
  - w_cols is passed through to the config only; it has no sequencing effect.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start_i=1 captures cfg_i, clears err_o and all counters, sets busy_o next cycle, goes to LOAD_W.
  - start_i while not in IDLE is ignored.
- LOAD_W:
  - w_rd_en_o=1 for w_rows+1 consecutive cycles with w_addr_o = w_offset + k, k = 0..w_rows.
  - After the last read, goes to STREAM. w_load_o trails by one cycle.
- STREAM:
  - Each cycle with stall_i=0 issues i_rd_en_o=1, i_addr_o = i_offset + n, then n increments.
  - With stall_i=1: i_rd_en_o=0 and n holds.
  - After issuing n = i_rows, goes to DRAIN.
- Psum read (when accum_en=1):
  - psum_rd_en_o follows i_rd_en_o delayed by (ROW+COL-1-PSUM_LEAD) cycles, via shift register.
  - psum_addr_o = psum_offset + p, with p incrementing per read.
  - With accum_en=0, psum_rd_en_o stays 0.
- Output write:
  - Each out_valid_i in STREAM or DRAIN gives o_wr_en_o=1 combinationally, o_addr_o = o_offset_w + m, then m increments.
  - out_valid_i in IDLE, LOAD_W or DONE is ignored.
- DRAIN:
  - When m reaches i_rows+1, goes to DONE.
  - A watchdog counts DRAIN cycles. At TIMEOUT it sets err_o and goes to DONE.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, then returns to IDLE.
- Address arithmetic:
  - Adds are truncated to address width, so addresses wrap modulo memory size.
  - Example: i_offset=250 with 10 rows gives 250..255, 0..3.
- Simultaneous last input issue and final out_valid_i: the FSM still passes through DRAIN. The DRAIN exit check uses the updated m.
- Reset mid-job: return to IDLE immediately. No partial done_o. Enables drop the same cycle.

Optional Feature:
- Macro MATRIX_MULT_CTRL_PERF_EN.
- Defined:
  - Adds outputs cycles_o (32 bits) and stall_cycles_o (32 bits).
  - cycles_o counts cycles with busy_o=1.
  - stall_cycles_o counts STREAM cycles with stall_i=1.
  - Both clear on accepted start and hold after DONE.
- Undefined: ports and counters are absent.

Decomposition:
- Package matrix_mult_pkg gets:
  - ctrl_state_e enum (IDLE, LOAD_W, STREAM, DRAIN, DONE)
  - CTRL_PIPE_LAT = ROW+COL-1
  - ctrl_status_struct (busy, done, err)
- Sub-module matrix_mult_addr_gen: offset register plus count-minus-one limit. Provides clear/increment, a wrapped address, and a last flag. Instantiated four times (weight, input, psum, output).

Test Plan:
- Basic job: w_rows=3, i_rows=7, offsets 0/16/0/32, accum_en=0, array model returning out_valid_i 7 cycles after each input.
  - w_addr 0..3, then i_addr 16..23, then o_addr 32..39.
  - done_o exactly once; psum_rd_en_o never high.
- Accumulate: same job with accum_en=1, psum_offset=64.
  - psum_addr 64..71.
  - Each psum_rd_en_o precedes the matching out_valid_i by PSUM_LEAD=1.
  - accum_o=1.
- Stall: stall_i high on cycles 2-4 of STREAM.
  - i_rd_en_o low on those cycles; no address skipped or repeated; job completes with 8 writes.
- Wrap: i_offset=252, i_rows=7, o_offset_w=254.
  - i_addr 252..255, 0..3.
  - o_addr 254, 255, 0..5.
- Timeout and reset:
  - Array model withholds the last out_valid_i: err_o=1 after 1023 DRAIN cycles, done_o pulses.
  - Separate run asserts rst_i mid-STREAM: all outputs 0 next cycle, then a new start runs cleanly with err_o cleared.
- Start ignored while busy: pulse start_i with a different cfg_i during STREAM.
  - Original addresses continue unchanged.
